// File: rtl/ark_round_stage.sv
// ark_round_stage
//   One AddRoundKey stage: XORs a state word with a round key, tags the
//   result with its round index and holds it in a small FIFO output buffer.
//
//   Parameters
//     DATA_WIDTH : bits per state-matrix cell (state word is 16*DATA_WIDTH)
//     NUM_ROUNDS : index of the final round (10, 12 or 14)
//     BUF_DEPTH  : output buffer entries (1 or 2)
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset
//     ip_data    : state word, MSB is the MSB of cell [0][0]
//     ip_key     : round key, same packing as ip_data
//     in_first   : beat is round 0 of a new block
//     in_valid   : input beat presented
//     in_ready   : stage accepts a beat this cycle
//     out        : XOR result of the head entry as out[row][col]
//     out_round  : round index of the head entry
//     out_last   : head entry carries round NUM_ROUNDS
//     out_valid  : head entry is valid
//     out_ready  : downstream consumes the head entry
//     seq_err    : sticky round-sequencing error
module ark_round_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROUNDS = 10,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [16*DATA_WIDTH-1:0]           ip_data,
    input  logic [16*DATA_WIDTH-1:0]           ip_key,
    input  logic                               in_first,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [0:3][0:3][DATA_WIDTH-1:0]    out,
    output logic [3:0]                         out_round,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               seq_err
);
    localparam int SW = 16 * DATA_WIDTH;

    // Buffer entries; entry 0 is always the head (shift-down FIFO), so the
    // outputs come straight from registers and stay stable under stall.
    logic [SW-1:0] data_reg  [BUF_DEPTH];
    logic [3:0]    tag_reg   [BUF_DEPTH];
    logic [SW-1:0] shift_data[BUF_DEPTH];
    logic [3:0]    shift_tag [BUF_DEPTH];

    logic [1:0] count_reg;
    logic [3:0] rnd_reg;
    logic [3:0] rnd_next;
    logic [3:0] tag_next;
    logic       err_next;
    logic       seq_err_reg;
    logic       live_reg;
    logic       push;
    logic       pop;
    logic [1:0] wr_idx;

    // Handshake. live_reg keeps in_ready low until the first edge after
    // reset is released.
    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = live_reg && ((count_reg < 2'(BUF_DEPTH)) || pop);
    assign push      = in_valid && in_ready;
    // On a simultaneous pop the entries move down one slot first, so the
    // new beat lands one position lower.
    assign wr_idx    = count_reg - {1'b0, pop};

    // Source of each entry when the buffer shifts down; the top entry has
    // no upper neighbour and simply keeps its (now stale) contents.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_shift
        if (gi < BUF_DEPTH - 1) begin : g_mid
            assign shift_data[gi] = data_reg[gi+1];
            assign shift_tag[gi]  = tag_reg[gi+1];
        end else begin : g_top
            assign shift_data[gi] = data_reg[gi];
            assign shift_tag[gi]  = tag_reg[gi];
        end
    end

    // Round tagging of the beat being offered.
    always_comb begin
        tag_next = 4'd0;
        rnd_next = 4'd1;
        err_next = 1'b0;
        if (in_first) begin
            // A restart while a block is still in progress is an error,
            // but the beat still starts a fresh block.
            err_next = (rnd_reg != 4'd0);
        end else if (rnd_reg == 4'd0) begin
            // Block should have started with in_first; treat as round 0.
            err_next = 1'b1;
        end else begin
            tag_next = rnd_reg;
            rnd_next = (rnd_reg == 4'(NUM_ROUNDS)) ? 4'd0 : rnd_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_reg    <= 1'b0;
            count_reg   <= 2'd0;
            rnd_reg     <= 4'd0;
            seq_err_reg <= 1'b0;
        end else begin
            live_reg  <= 1'b1;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            if (push) begin
                rnd_reg <= rnd_next;
                if (err_next) begin
                    seq_err_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_reg[i] <= '0;
                tag_reg[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (push && wr_idx == 2'(i)) begin
                    data_reg[i] <= ip_data ^ ip_key;
                    tag_reg[i]  <= tag_next;
                end else if (pop) begin
                    data_reg[i] <= shift_data[i];
                    tag_reg[i]  <= shift_tag[i];
                end
            end
        end
    end

    // Column-major unpacking of the head word into the row/column matrix:
    // cell [row][col] is the (4*col+row)-th cell counted from the MSB.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        for (genvar gj = 0; gj < 4; gj++) begin : g_row
            assign out[gj][gi] =
                data_reg[0][SW-1-4*DATA_WIDTH*gi-DATA_WIDTH*gj -: DATA_WIDTH];
        end
    end

    assign out_round = tag_reg[0];
    assign out_last  = (tag_reg[0] == 4'(NUM_ROUNDS));
    assign seq_err   = seq_err_reg;

endmodule

// File: tb/tb_ark_round_stage.sv
module tb_ark_round_stage;
    localparam int DW = 8;
    localparam int SW = 16 * DW;
    localparam int NR = 10;
    localparam int BD = 2;

    typedef logic [0:3][0:3][DW-1:0] mat_t;
    typedef struct {
        logic [SW-1:0] x;
        int            rnd;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance (NUM_ROUNDS=10, BUF_DEPTH=2)
    logic [SW-1:0] ip_data, ip_key;
    logic          in_first, in_valid, in_ready;
    mat_t          out;
    logic [3:0]    out_round;
    logic          out_last, out_valid, out_ready, seq_err;

    // second instance (NUM_ROUNDS=14)
    logic [SW-1:0] ip_data2, ip_key2;
    logic          in_first2, in_valid2, in_ready2;
    mat_t          out2;
    logic [3:0]    out_round2;
    logic          out_last2, out_valid2, out_ready2, seq_err2;

    ark_round_stage #(.DATA_WIDTH(DW), .NUM_ROUNDS(NR), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .ip_data(ip_data), .ip_key(ip_key),
        .in_first(in_first), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_round(out_round), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .seq_err(seq_err)
    );

    ark_round_stage #(.DATA_WIDTH(DW), .NUM_ROUNDS(14), .BUF_DEPTH(2)) dut14 (
        .clk(clk), .rst(rst), .ip_data(ip_data2), .ip_key(ip_key2),
        .in_first(in_first2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out(out2), .out_round(out_round2), .out_last(out_last2),
        .out_valid(out_valid2), .out_ready(out_ready2), .seq_err(seq_err2)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    beat_t mq[$];
    int    m_rnd;
    bit    m_err;
    bit    m_live;
    bit    exp_ready;
    bit    seen_ready;

    function automatic logic [SW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // cell [row][col] is the (4*col+row)-th DW-bit chunk from the MSB
    function automatic mat_t exp_mat(input logic [SW-1:0] x);
        mat_t m;
        logic [SW-1:0] s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = x >> (SW - DW * (4 * c + r + 1));
                m[r][c] = s[DW-1:0];
            end
        end
        return m;
    endfunction

    // One clock cycle on the main instance: drive at the falling edge,
    // record in_ready, advance the model at the rising edge, return at the
    // next falling edge where outputs are sampled.
    task automatic cycle(input bit v, input bit f, input bit ordy,
                         input logic [SW-1:0] d, input logic [SW-1:0] k);
        beat_t b;
        bit    pop;
        in_valid  = v;
        in_first  = f;
        out_ready = ordy;
        ip_data   = d;
        ip_key    = k;
        #1;
        pop        = ordy && (mq.size() > 0);
        exp_ready  = m_live && ((mq.size() < BD) || pop);
        seen_ready = in_ready;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (v && exp_ready) begin
            b.x = d ^ k;
            if (f || m_rnd == 0) begin
                if (!f || m_rnd != 0) m_err = 1'b1;
                b.rnd = 0;
                m_rnd = 1;
            end else begin
                b.rnd = m_rnd;
                m_rnd = (m_rnd == NR) ? 0 : m_rnd + 1;
            end
            mq.push_back(b);
            $display("accept t=%0t first=%0b round=%0d x=%032h", $time, f, b.rnd, b.x);
        end
        m_live = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 0; in_first = 0; out_ready = 0; ip_data = '0; ip_key = '0;
        in_valid2 = 0; in_first2 = 0; out_ready2 = 0; ip_data2 = '0; ip_key2 = '0;
        mq.delete();
        m_rnd = 0; m_err = 0; m_live = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1; in_first = 1; out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
        total++; if (out_round !== 4'd0) begin bad++; $display("FAIL reset_out_round got=%0d want=0", out_round); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%b want=0", seq_err); end
        apply_reset();
        // in_ready stays low until the first edge after release
        cycle(0, 0, 0, '0, '0);
        total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL reset_release_ready got=%b want=0", seen_ready); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise got=%b want=1", in_ready); end
    endtask

    task automatic test_fips();
        mat_t m;
        apply_reset();
        cycle(0, 0, 0, '0, '0);
        cycle(1, 1, 0, 128'h00112233445566778899aabbccddeeff,
                       128'h000102030405060708090a0b0c0d0e0f);
        m = out;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fips_valid got=%b want=1", out_valid); end
        total++; if (m[0][0] !== 8'h00) begin bad++; $display("FAIL fips_00 got=%h want=00", m[0][0]); end
        total++; if (m[1][0] !== 8'h10) begin bad++; $display("FAIL fips_10 got=%h want=10", m[1][0]); end
        total++; if (m[3][0] !== 8'h30) begin bad++; $display("FAIL fips_30 got=%h want=30", m[3][0]); end
        total++; if (m[0][1] !== 8'h40) begin bad++; $display("FAIL fips_01 got=%h want=40", m[0][1]); end
        total++; if (m[3][3] !== 8'hf0) begin bad++; $display("FAIL fips_33 got=%h want=f0", m[3][3]); end
        total++; if (out_round !== 4'd0) begin bad++; $display("FAIL fips_round got=%0d want=0", out_round); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL fips_last got=%b want=0", out_last); end
        cycle(0, 0, 1, '0, '0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fips_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_full_block();
        apply_reset();
        cycle(0, 0, 1, '0, '0);
        for (int i = 0; i <= NR; i++) begin
            cycle(1, i == 0, 1, rand_word(), rand_word());
            total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL blk_ready beat=%0d got=%b want=1", i, seen_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL blk_valid beat=%0d got=%b want=1", i, out_valid); end
            total++; if (out_round !== 4'(i)) begin bad++; $display("FAIL blk_round beat=%0d got=%0d want=%0d", i, out_round, i); end
            total++; if (out_last !== (i == NR)) begin bad++; $display("FAIL blk_last beat=%0d got=%b want=%b", i, out_last, i == NR); end
            total++; if (out !== exp_mat(mq[0].x)) begin bad++; $display("FAIL blk_data beat=%0d got=%h want=%h", i, out, exp_mat(mq[0].x)); end
        end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL blk_seq_err got=%b want=0", seq_err); end
        cycle(0, 0, 1, '0, '0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL blk_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] first_x, second_x;
        apply_reset();
        cycle(0, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, i == 0, 0, rand_word(), rand_word());
            total++; if (seen_ready !== (i < 2)) begin bad++; $display("FAIL bp_ready beat=%0d got=%b want=%b", i, seen_ready, i < 2); end
        end
        first_x  = mq[0].x;
        second_x = mq[1].x;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
        total++; if (out !== exp_mat(first_x)) begin bad++; $display("FAIL bp_hold got=%h want=%h", out, exp_mat(first_x)); end
        cycle(0, 0, 1, '0, '0);
        total++; if (out !== exp_mat(second_x) || out_round !== 4'd1) begin bad++; $display("FAIL bp_second got=%h/%0d want=%h/1", out, out_round, exp_mat(second_x)); end
        cycle(0, 0, 1, '0, '0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_seq_err();
        apply_reset();
        cycle(0, 0, 1, '0, '0);
        cycle(1, 0, 1, rand_word(), rand_word());
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL seq_nofirst_err got=%b want=1", seq_err); end
        total++; if (out_round !== 4'd0) begin bad++; $display("FAIL seq_nofirst_round got=%0d want=0", out_round); end
        apply_reset();
        cycle(0, 0, 1, '0, '0);
        for (int i = 0; i < 5; i++) cycle(1, i == 0, 1, rand_word(), rand_word());
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL seq_clean got=%b want=0", seq_err); end
        cycle(1, 1, 1, rand_word(), rand_word());
        total++; if (seq_err !== 1'b1 || out_round !== 4'd0) begin bad++; $display("FAIL seq_restart got=%b/%0d want=1/0", seq_err, out_round); end
        cycle(1, 0, 1, rand_word(), rand_word());
        total++; if (out_round !== 4'd1) begin bad++; $display("FAIL seq_after_restart got=%0d want=1", out_round); end
        // stalled cycles must not move the round counter or clear the flag
        cycle(0, 0, 1, '0, '0);
        cycle(0, 0, 1, '0, '0);
        cycle(1, 0, 1, rand_word(), rand_word());
        total++; if (out_round !== 4'd2 || seq_err !== 1'b1) begin bad++; $display("FAIL seq_stall got=%0d/%b want=2/1", out_round, seq_err); end
    endtask

    task automatic test_random();
        bit v, f, r;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 2) != 0);
            cycle(v, f, r, rand_word(), rand_word());
            total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, seen_ready, exp_ready); end
            total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, out_valid, mq.size() > 0); end
            total++; if (seq_err !== m_err) begin bad++; $display("FAIL rnd_seq_err n=%0d got=%b want=%b", n, seq_err, m_err); end
            if (mq.size() > 0) begin
                total++; if (out_round !== 4'(mq[0].rnd) || out_last !== (mq[0].rnd == NR)) begin bad++; $display("FAIL rnd_round n=%0d got=%0d/%b want=%0d", n, out_round, out_last, mq[0].rnd); end
                total++; if (out !== exp_mat(mq[0].x)) begin bad++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, out, exp_mat(mq[0].x)); end
            end
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        cycle(0, 0, 0, '0, '0);
        cycle(1, 1, 0, rand_word(), rand_word());
        cycle(1, 0, 0, rand_word(), rand_word());
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b/%b want=1/0", out_valid, in_ready); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
        total++; if (out !== '0 || out_round !== 4'd0 || out_last !== 1'b0) begin bad++; $display("FAIL mid_outputs got=%h/%0d/%b want=0", out, out_round, out_last); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", in_ready); end
        mq.delete();
        m_rnd = 0; m_err = 0; m_live = 0;
        in_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, '0, '0);
        cycle(1, 1, 0, rand_word(), rand_word());
        total++; if (out_valid !== 1'b1 || out_round !== 4'd0 || seq_err !== 1'b0) begin bad++; $display("FAIL mid_first got=%b/%0d/%b want=1/0/0", out_valid, out_round, seq_err); end
        total++; if (out !== exp_mat(mq[0].x)) begin bad++; $display("FAIL mid_data got=%h want=%h", out, exp_mat(mq[0].x)); end
    endtask

    task automatic test_rounds14();
        logic [SW-1:0] d, k;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i <= 15; i++) begin
            d = rand_word();
            k = rand_word();
            in_valid2 = 1; in_first2 = (i == 0); out_ready2 = 1;
            ip_data2 = d; ip_key2 = k;
            #1;
            total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL r14_ready beat=%0d got=%b want=1", i, in_ready2); end
            @(posedge clk);
            @(negedge clk);
            $display("accept14 t=%0t beat=%0d round=%0d last=%b", $time, i, out_round2, out_last2);
            // beat 15 follows the wrap to 0 without in_first: tagged 0, error
            total++; if (out_round2 !== 4'(i % 15)) begin bad++; $display("FAIL r14_round beat=%0d got=%0d want=%0d", i, out_round2, i % 15); end
            total++; if (out_last2 !== (i == 14)) begin bad++; $display("FAIL r14_last beat=%0d got=%b want=%b", i, out_last2, i == 14); end
            total++; if (seq_err2 !== (i == 15)) begin bad++; $display("FAIL r14_seq_err beat=%0d got=%b want=%b", i, seq_err2, i == 15); end
            total++; if (out2 !== exp_mat(d ^ k)) begin bad++; $display("FAIL r14_data beat=%0d got=%h want=%h", i, out2, exp_mat(d ^ k)); end
        end
        in_valid2 = 0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_first = 0; out_ready = 0; ip_data = '0; ip_key = '0;
        in_valid2 = 0; in_first2 = 0; out_ready2 = 0; ip_data2 = '0; ip_key2 = '0;
        m_rnd = 0; m_err = 0; m_live = 0;
        test_reset();
        test_fips();
        test_full_block();
        test_backpressure();
        test_seq_err();
        test_random();
        test_midreset();
        test_rounds14();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
